stream_merge: RTL and testbench

STREAM_MERGE -- requirements
Module: stream_merge

---
 rtl/stream_merge_pkg.sv | 6 +
 rtl/stream_merge_out_slice.sv | 40 ++++
 rtl/stream_merge.sv | 85 ++++++++
 tb/tb_stream_merge.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/stream_merge_pkg.sv
// stream_merge_pkg: shared FSM state and merge-order constants for stream_merge
package stream_merge_pkg;
    typedef enum logic [1:0] {S_MERGE, S_DRAIN_A, S_DRAIN_B} state_t;
    localparam logic MODE_ASC  = 1'b0;
    localparam logic MODE_DESC = 1'b1;
endpackage

// File: rtl/stream_merge_out_slice.sv
// merge_out_slice: registered output element with hold-while-stalled behaviour
module merge_out_slice #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_CNT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 ready,
    input  logic [SIZE_DATA-1:0] data,
    input  logic                 last,
    input  logic                 src,
    input  logic [SIZE_CNT-1:0]  len,
    output logic                 q_valid,
    output logic [SIZE_DATA-1:0] q_data,
    output logic                 q_last,
    output logic                 q_src,
    output logic [SIZE_CNT-1:0]  q_len,
    output logic                 slot_free
);
    assign slot_free = !q_valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_last  <= 1'b0;
            q_src   <= 1'b0;
            q_len   <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= data;
            q_last  <= last;
            q_src   <= src;
            q_len   <= len;
        end else if (ready) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_merge.sv
// stream_merge: merges two sorted runs into one ordered run with registered output
module stream_merge
    import stream_merge_pkg::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_CNT  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mode,
    input  logic                 i_a_valid,
    input  logic                 i_a_last,
    input  logic [SIZE_DATA-1:0] i_a_data,
    output logic                 o_a_ready,
    input  logic                 i_b_valid,
    input  logic                 i_b_last,
    input  logic [SIZE_DATA-1:0] i_b_data,
    output logic                 o_b_ready,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_src,
    output logic [SIZE_DATA-1:0] o_data,
    input  logic                 i_ready,
    output logic [SIZE_CNT-1:0]  o_len
);
    state_t state, state_nx;
    logic [SIZE_CNT-1:0] cnt, cnt_inc;
    logic mode_q, mode_eff, pick_a, slot_free, acc_a, acc_b, load, sel_last, out_last;
    logic [SIZE_DATA-1:0] sel_data;

    // an empty counter means no element of the current run has been accepted yet
    assign mode_eff  = (cnt == '0) ? i_mode : mode_q;
    assign pick_a    = (mode_eff == MODE_DESC) ? (i_a_data >= i_b_data) : (i_a_data <= i_b_data);
    assign o_a_ready = !i_rst && slot_free &&
                       ((state == S_MERGE) ? (i_a_valid && i_b_valid && pick_a) : (state == S_DRAIN_A));
    assign o_b_ready = !i_rst && slot_free &&
                       ((state == S_MERGE) ? (i_a_valid && i_b_valid && !pick_a) : (state == S_DRAIN_B));
    assign acc_a     = o_a_ready && i_a_valid;
    assign acc_b     = o_b_ready && i_b_valid;
    assign load      = acc_a || acc_b;
    assign sel_data  = acc_a ? i_a_data : i_b_data;
    assign sel_last  = acc_a ? i_a_last : i_b_last;
    assign out_last  = load && sel_last && (state != S_MERGE);
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = S_MERGE;
        if (state == S_MERGE)
            state_nx = (acc_a && i_a_last) ? S_DRAIN_B : (acc_b && i_b_last) ? S_DRAIN_A : S_MERGE;
        else if (state == S_DRAIN_A || state == S_DRAIN_B)
            state_nx = out_last ? S_MERGE : state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_MERGE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            mode_q <= MODE_ASC;
        end else if (load) begin
            cnt <= out_last ? '0 : cnt_inc;
            if (cnt == '0) mode_q <= i_mode;
        end
    end

    merge_out_slice #(.SIZE_DATA(SIZE_DATA), .SIZE_CNT(SIZE_CNT)) u_out (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .ready    (i_ready),
        .data     (sel_data),
        .last     (out_last),
        .src      (acc_b),
        .len      (cnt_inc),
        .q_valid  (o_valid),
        .q_data   (o_data),
        .q_last   (o_last),
        .q_src    (o_src),
        .q_len    (o_len),
        .slot_free(slot_free)
    );
endmodule

// File: tb/tb_stream_merge.sv
// tb_stream_merge: scoreboard bench for stream_merge
module tb_stream_merge;
    import stream_merge_pkg::*;

    logic       clk = 0, rst = 1, mode = 0;
    logic       a_valid = 0, a_last = 0, b_valid = 0, b_last = 0;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, b_ready, o_valid, o_last, o_src, rdy = 1;
    logic [7:0] o_data, o_len;

    typedef struct {logic [7:0] d; logic s; logic l; logic [7:0] n;} exp_t;
    exp_t       sb[$];
    logic [7:0] qa[$], qb[$];
    int         n_checks = 0, n_fail = 0;

    stream_merge dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode),
        .i_a_valid(a_valid), .i_a_last(a_last), .i_a_data(a_data), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_last(b_last), .i_b_data(b_data), .o_b_ready(b_ready),
        .o_valid(o_valid), .o_last(o_last), .o_src(o_src), .o_data(o_data),
        .i_ready(rdy), .o_len(o_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic l, input logic [7:0] n);
        exp_t e;
        e.d = d; e.s = s; e.l = l; e.n = n;
        sb.push_back(e);
    endtask

    task automatic run(input logic md, input int stall, input int b_delay, input int rst_after,
                       input int flip_at, input bit chk_drain);
        int ia = 0, ib = 0, cyc = 0, emitted = 0, accepted = 0;
        bit held = 0, flipped = 0, acc_a, acc_b;
        logic [7:0] hd;
        exp_t e;
        mode = md;
        while (sb.size() > 0 && cyc < 300) begin
            a_valid = ia < qa.size();
            a_data  = a_valid ? qa[ia] : 8'h0;
            a_last  = a_valid && ia == qa.size() - 1;
            b_valid = cyc >= b_delay && ib < qb.size();
            b_data  = b_valid ? qb[ib] : 8'h0;
            b_last  = b_valid && ib == qb.size() - 1;
            rdy     = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (flip_at >= 0 && !flipped && accepted == flip_at) begin
                mode = ~mode;
                flipped = 1;
            end
            @(negedge clk);
            if (cyc < b_delay) begin
                check("wait_a_ready", a_ready, 0);
                check("wait_o_valid", o_valid, 0);
            end
            if (held) check("hold_data", o_data, hd);
            held = o_valid && !rdy;
            hd = o_data;
            if (chk_drain && o_valid && o_data == 8'd5) check("drain_b_state", dut.state, S_DRAIN_B);
            if (o_valid && rdy) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("data", o_data, e.d);
                    check("src", o_src, e.s);
                    check("last", o_last, e.l);
                    if (e.l) check("len", o_len, e.n);
                end
                emitted++;
            end
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            if (acc_a && acc_b) check("one_accept", 1, 0);
            @(posedge clk);
            #1;
            if (acc_a) ia++;
            if (acc_b) ib++;
            if (acc_a || acc_b) accepted++;
            cyc++;
            if (rst_after > 0 && emitted == rst_after) begin
                rst = 1;
                #1;
                check("rst_valid", o_valid, 0);
                check("rst_data", o_data, 0);
                check("rst_last", o_last, 0);
                check("rst_len", o_len, 0);
                check("rst_a_ready", a_ready, 0);
                check("rst_b_ready", b_ready, 0);
                sb.delete();
                @(posedge clk);
                #1;
                rst = 0;
            end
        end
        check("timeout_pending", sb.size(), 0);
        a_valid = 0; b_valid = 0; rdy = 1;
        qa.delete(); qb.delete();
    endtask

    initial begin
        a_valid = 1; b_valid = 1; a_data = 1; b_data = 2;
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_len", o_len, 0);
        check("reset_data", o_data, 0);
        check("reset_a_ready", a_ready, 0);
        check("reset_b_ready", b_ready, 0);
        a_valid = 0; b_valid = 0;
        @(posedge clk); #1; rst = 0;

        qa = '{1, 4, 9}; qb = '{2, 4, 7};
        push(1, 0, 0, 0); push(2, 1, 0, 0); push(4, 0, 0, 0);
        push(4, 1, 0, 0); push(7, 1, 0, 0); push(9, 0, 1, 6);
        run(MODE_ASC, 0, 0, 0, -1, 0);

        qa = '{9, 5}; qb = '{8, 3, 1};
        push(9, 0, 0, 0); push(8, 1, 0, 0); push(5, 0, 0, 0);
        push(3, 1, 0, 0); push(1, 1, 1, 5);
        run(MODE_DESC, 0, 0, 0, -1, 1);

        qa = '{3}; qb = '{10, 11, 12};
        push(3, 0, 0, 0); push(10, 1, 0, 0); push(11, 1, 0, 0); push(12, 1, 1, 4);
        run(MODE_ASC, 1, 0, 0, -1, 0);

        qa = '{5}; qb = '{6};
        push(5, 0, 0, 0); push(6, 1, 1, 2);
        run(MODE_ASC, 0, 5, 0, -1, 0);

        qa = '{1, 3, 5}; qb = '{2, 4, 6};
        push(1, 0, 0, 0); push(2, 1, 0, 0); push(3, 0, 0, 0);
        push(4, 1, 0, 0); push(5, 0, 0, 0); push(6, 1, 1, 6);
        run(MODE_ASC, 0, 0, 2, -1, 0);

        qa = '{5}; qb = '{6};
        push(5, 0, 0, 0); push(6, 1, 1, 2);
        run(MODE_ASC, 0, 0, 0, -1, 0);

        qa = '{1, 3, 5}; qb = '{2, 4, 6};
        push(1, 0, 0, 0); push(2, 1, 0, 0); push(3, 0, 0, 0);
        push(4, 1, 0, 0); push(5, 0, 0, 0); push(6, 1, 1, 6);
        run(MODE_ASC, 0, 0, 0, 2, 0);

        qa = '{8, 2}; qb = '{7};
        push(8, 0, 0, 0); push(7, 1, 0, 0); push(2, 0, 1, 3);
        run(MODE_DESC, 0, 0, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
